reaction_timer: RTL and testbench

Parametrised reaction-time measurement block for the reaction-test course designs. It replaces the fixed 4-digit, 8-button timer with configurable prescale, BCD digit count and button count. It adds explicit FSM control, wrong-button, timeout and false-start outcomes, and a best-time register. It sits between the debounced button bank and the seven-segment display driver, which shows the BCD result.

---
 rtl/reaction_timer_pkg.sv | 17 +
 rtl/reaction_timer_bcd_digit.sv | 22 ++
 rtl/reaction_timer.sv | 123 ++++++++++++
 tb/tb_reaction_timer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/reaction_timer_pkg.sv
// Shared types and helpers for the reaction timer: FSM states, BCD constants,
// prescaler width helper.
package reaction_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_NINE = 4'd9;

  function automatic int presc_w(input int clk_per_ms);
    return (clk_per_ms <= 2) ? 1 : $clog2(clk_per_ms);
  endfunction

endpackage

// File: rtl/reaction_timer_bcd_digit.sv
// One BCD digit of the elapsed-time counter; carry_out feeds the next digit.
import reaction_pkg::*;

module bcd_digit (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] dig,
  output logic       carry_out
);

  assign carry_out = inc & (dig == BCD_NINE);

  always_ff @(posedge clk) begin
    if (rst || clr)
      dig <= 4'd0;
    else if (inc)
      dig <= (dig == BCD_NINE) ? 4'd0 : dig + 4'd1;
  end

endmodule

// File: rtl/reaction_timer.sv
// Reaction-time measurement: ms prescaler, BCD elapsed counter, outcome flags
// and best-hit register, sequenced by an IDLE/RUN/DONE FSM.
import reaction_pkg::*;

module reaction_timer #(
  parameter int CLK_PER_MS = 12000,
  parameter int DIGITS     = 4,
  parameter int BTN_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  det_start,
  input  logic                  restart,
  input  logic [BTN_W-1:0]      btn_deb,
  input  logic [BTN_W-1:0]      bit_sel,
  output logic                  det_end,
  output logic                  busy,
  output logic [4*DIGITS-1:0]   result,
  output logic [4*DIGITS-1:0]   best,
  output logic                  hit,
  output logic                  wrong,
  output logic                  timeout,
  output logic                  false_start
);

  localparam int PW = presc_w(CLK_PER_MS);

  state_t                    state;
  logic [PW-1:0]             presc;
  logic [DIGITS-1:0][3:0]    digs;
  logic [DIGITS-1:0]         inc;
  logic [DIGITS-1:0]         carry;
  logic [DIGITS-1:0]         nine;
  logic [BTN_W-1:0]          pressed;
  logic                      tick, all_nine, hit_c, wrong_c, clr, tick_inc;

  assign pressed  = ~btn_deb;
  assign hit_c    = (pressed == bit_sel);
  assign wrong_c  = (pressed != '0) && !hit_c;
  assign tick     = (presc == PW'(CLK_PER_MS - 1));
  assign all_nine = &nine;

  // Any honoured det_start zeroes the result: arming, re-arming or false start.
  assign clr = det_start && ((state != RUN) || !restart);

  // Counting only happens on an uninterrupted RUN cycle; all-nines saturates.
  assign tick_inc = (state == RUN) && !restart && !det_start && !hit_c &&
                    !wrong_c && tick && !all_nine;

  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
      if (i == 0) begin : g_lsd
        assign inc[i] = tick_inc;
      end else begin : g_upper
        assign inc[i] = carry[i-1];
      end
      assign nine[i] = (digs[i] == BCD_NINE);
      bcd_digit u_dig (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .inc       (inc[i]),
        .dig       (digs[i]),
        .carry_out (carry[i])
      );
    end
  endgenerate

  assign result  = digs;
  assign busy    = (state == RUN);
  // A restart coinciding with DONE swallows the end pulse.
  assign det_end = (state == DONE) && !restart;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      presc       <= '0;
      best        <= {DIGITS{BCD_NINE}};
      hit         <= 1'b0;
      wrong       <= 1'b0;
      timeout     <= 1'b0;
      false_start <= 1'b0;
    end else begin
      if (state == DONE && hit && (result < best))
        best <= result;

      case (state)
        IDLE, DONE: begin
          if (det_start) begin
            presc       <= '0;
            hit         <= 1'b0;
            wrong       <= 1'b0;
            timeout     <= 1'b0;
            false_start <= (pressed != '0);
            state       <= (pressed == '0) ? RUN : DONE;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (restart) begin
            state <= IDLE;
          end else if (det_start) begin
            presc <= '0;
          end else if (hit_c) begin
            hit   <= 1'b1;
            state <= DONE;
          end else if (wrong_c) begin
            wrong <= 1'b1;
            state <= DONE;
          end else if (tick && all_nine) begin
            timeout <= 1'b1;
            state   <= DONE;
          end else begin
            presc <= tick ? '0 : presc + PW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_timer.sv
// Directed bench for reaction_timer with CLK_PER_MS=4, DIGITS=2, BTN_W=4.
module tb_reaction_timer;

  localparam int CPM = 4;

  logic       clk = 1'b0;
  logic       rst, det_start, restart;
  logic [3:0] btn_deb, bit_sel;
  logic       det_end, busy, hit, wrong, timeout, false_start;
  logic [7:0] result, best;

  int n_tests = 0;
  int n_fail  = 0;
  int de_cnt  = 0;
  int de_ref;

  reaction_timer #(.CLK_PER_MS(CPM), .DIGITS(2), .BTN_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .det_start   (det_start),
    .restart     (restart),
    .btn_deb     (btn_deb),
    .bit_sel     (bit_sel),
    .det_end     (det_end),
    .busy        (busy),
    .result      (result),
    .best        (best),
    .hit         (hit),
    .wrong       (wrong),
    .timeout     (timeout),
    .false_start (false_start)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (det_end === 1'b1) de_cnt++;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    det_start = 1'b1;
    step(1);
    det_start = 1'b0;
  endtask

  // flags packed as {hit, wrong, timeout, false_start}
  function automatic logic [3:0] flags();
    return {hit, wrong, timeout, false_start};
  endfunction

  initial begin
    rst = 1'b1; det_start = 1'b0; restart = 1'b0;
    btn_deb = 4'b1111; bit_sel = 4'b0100;
    step(2);
    rst = 1'b0;
    step(5);
    chk("rst_result", result, 8'h00);
    chk("rst_best",   best,   8'h99);
    chk("rst_flags",  flags(), 4'b0000);
    chk("rst_busy",   busy,   1'b0);
    chk("rst_no_end", de_cnt, 0);

    // hit at ms 37
    pulse_start();
    chk("h37_busy", busy, 1'b1);
    step(CPM*37 + 1);
    btn_deb = 4'b1011;
    step(1);
    btn_deb = 4'b1111;
    chk("h37_end",    det_end, 1'b1);
    chk("h37_result", result,  8'h37);
    chk("h37_flags",  flags(), 4'b1000);
    chk("h37_busy0",  busy,    1'b0);
    step(1);
    chk("h37_best",   best,    8'h37);
    chk("h37_end0",   det_end, 1'b0);
    chk("h37_cnt",    de_cnt,  1);

    // slower hit at ms 52 leaves best alone
    pulse_start();
    step(CPM*52);
    btn_deb = 4'b1011;
    step(1);
    btn_deb = 4'b1111;
    chk("h52_result", result, 8'h52);
    step(1);
    chk("h52_best",   best,   8'h37);

    // wrong button at ms 12
    pulse_start();
    step(CPM*12);
    btn_deb = 4'b1110;
    step(1);
    btn_deb = 4'b1111;
    chk("wr_end",    det_end, 1'b1);
    chk("wr_flags",  flags(), 4'b0100);
    chk("wr_result", result,  8'h12);
    step(1);
    chk("wr_best",   best,    8'h37);

    // timeout: saturate at 99
    de_ref = de_cnt;
    pulse_start();
    step(CPM*100 + 5);
    chk("to_flags",  flags(), 4'b0010);
    chk("to_result", result,  8'h99);
    chk("to_busy",   busy,    1'b0);
    chk("to_once",   de_cnt,  de_ref + 1);
    chk("to_best",   best,    8'h37);

    // false start
    btn_deb = 4'b1101;
    pulse_start();
    btn_deb = 4'b1111;
    chk("fs_end",    det_end, 1'b1);
    chk("fs_flags",  flags(), 4'b0001);
    chk("fs_result", result,  8'h00);
    chk("fs_busy",   busy,    1'b0);
    step(1);

    // silent abort at ms 20
    de_ref = de_cnt;
    pulse_start();
    step(CPM*20);
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    step(2);
    chk("ab_busy",   busy,    1'b0);
    chk("ab_result", result,  8'h20);
    chk("ab_flags",  flags(), 4'b0000);
    chk("ab_no_end", de_cnt,  de_ref);

    // hit on the wrap cycle at 09: tick discarded
    pulse_start();
    step(CPM*9 + 3);
    btn_deb = 4'b1011;
    step(1);
    btn_deb = 4'b1111;
    chk("wp_result", result,  8'h09);
    chk("wp_flags",  flags(), 4'b1000);
    step(1);
    chk("wp_best",   best,    8'h09);

    // re-arm mid-run at ms 30
    de_ref = de_cnt;
    pulse_start();
    step(CPM*30);
    chk("ra_pre",    result, 8'h30);
    pulse_start();
    chk("ra_clr",    result, 8'h00);
    chk("ra_busy",   busy,   1'b1);
    step(CPM*5);
    chk("ra_5ms",    result, 8'h05);
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    chk("ra_no_end", de_cnt, de_ref);

    // reset restores best
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("rst2_best",   best,   8'h99);
    chk("rst2_result", result, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
